signed_divider_seq: RTL and testbench
=====================================

// Module: signed_divider_seq
//
// PURPOSE
//  Sequential two's-complement divider: q = a / b, r = a % b, truncating toward zero.
//  Iterative shift-and-subtract engine, one quotient bit per clock.
//  Inverse companion of the combinational 4-bit adder/subtractor.
//  Start/busy/done handshake towards the datapath controller.
//
// PARAMETERS
//  WIDTH  4  operand/result width in bits (two's complement); must be >= 2
//
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      synchronous reset, active-high
//  start     in   1      request; sampled only in IDLE
//  a         in   WIDTH  signed dividend, sampled when start is accepted
//  b         in   WIDTH  signed divisor, sampled when start is accepted
//  busy      out  1      high while a division is in progress (not IDLE)
//  done      out  1      one-cycle pulse; q/r/flags valid from this cycle on
//  q         out  WIDTH  signed quotient
//  r         out  WIDTH  signed remainder, sign follows dividend (or 0)
//  overflow  out  1      quotient not representable (a = -2^(W-1), b = -1)
//  div_zero  out  1      b was 0
//
// BEHAVIOUR
//  Clock/reset: one clock; reset is synchronous and active-high.
//  Reset: state=IDLE; busy, done, q, r, overflow, div_zero all 0.
//    rst mid-operation aborts the division; no done pulse is produced.
//  States:
//    IDLE -> CALC   on start, b!=0
//    IDLE -> DONE   on start, b==0
//    CALC -> CALC   while iteration count < WIDTH
//    CALC -> DONE   after the WIDTH-th iteration
//    DONE -> IDLE   unconditionally; done=1 only in DONE
//  Accept cycle: latch |a| and |b| as WIDTH-bit unsigned (|-2^(W-1)| = 2^(W-1) fits).
//    Also latch sign_q = a[W-1]^b[W-1] and sign_r = a[W-1]. Clear the count.
//  CALC step (unsigned, W+1-bit partial remainder P, dividend shift reg D):
//    {P,D} <<= 1; if P >= |b| then P -= |b| and D[0]=1, else D[0]=0. One step per cycle.
//  Latency: start in cycle N with b!=0 -> done in cycle N+WIDTH+1.
//    With b==0 -> done in cycle N+1.
//  DONE results (registered; held until the next accepted start or reset):
//    q = sign_q ? -D : D, truncated to WIDTH; r = sign_r ? -P : P.
//    overflow=1 iff a=-2^(W-1) and b=-1; then q=-2^(W-1) (wrapped), r=0.
//    div_zero=1 iff b==0; then q=all ones (-1), r=a, overflow=0.
//  Flags are cleared on the next accepted start.
//  start while busy: ignored; a/b changes while busy have no effect.
//  start held high: re-accepted in the IDLE cycle following DONE.
//    So back-to-back ops are spaced WIDTH+2 cycles apart.
//  busy=1 in CALC and DONE; busy=0 in IDLE.
//
// TESTING
//  7/2: a=7, b=2 -> done at N+5; q=3, r=1, flags 0.
//  Sign combinations:
//    -7/2 -> q=-3, r=-1; 7/-2 -> q=-3, r=1; -7/-2 -> q=3, r=-1; -8/3 -> q=-2, r=-2.
//  Limits: -8/-1 -> q=-8, r=0, overflow=1; -8/1 -> q=-8, r=0, overflow=0.
//  Divide by zero: a=5, b=0 -> done at N+1; q=-1 (4'hF), r=5, div_zero=1.
//  Protocol: start pulsed again mid-CALC with new a/b -> ignored, first result intact.
//    Then rst in 2nd CALC cycle -> all outputs 0, no done.
//    Then exhaustive 256-pair sweep vs reference model.
//  Held start: start=1 continuously -> done every 6 cycles; busy low exactly 1 cycle each gap.

Source files
------------

// File: rtl/signed_divider_seq.sv
// signed_divider_seq: sequential two's-complement divider, q = a / b and r = a % b,
// both truncating toward zero. A restoring shift-and-subtract engine on the operand
// magnitudes produces one quotient bit per clock. The signs are applied when the
// result is written.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-high; aborts any division in progress
//   start     request, sampled only while idle; a and b are captured on acceptance
//   a, b      signed dividend and divisor (WIDTH bits)
//   busy      high while a division is in progress (calculating or done)
//   done      one-cycle pulse; q, r and the flags are valid from this cycle on
//   q, r      signed quotient and remainder; the remainder takes the dividend's sign
//   overflow  quotient not representable (most-negative / -1)
//   div_zero  divisor was zero; q = -1 and r = a
module signed_divider_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             overflow,
  output logic             div_zero
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] p_q;      // partial remainder, always < |b| so WIDTH bits suffice
  logic [WIDTH-1:0] d_q;      // dividend shift register, fills with quotient bits
  logic [WIDTH-1:0] babs_q;
  logic [CntW-1:0]  cnt_q;
  logic             sign_q_q;
  logic             sign_r_q;
  logic             ovf_q;

  logic [WIDTH-1:0] a_abs, b_abs;
  logic             a_is_min, b_is_neg1;
  logic [WIDTH:0]   p_shift;
  logic             q_bit;
  logic [WIDTH-1:0] p_next, d_next, q_res, r_res;

  always_comb begin
    // |most-negative| = 2^(WIDTH-1) still fits as an unsigned WIDTH-bit value
    a_abs     = a[WIDTH-1] ? (-a) : a;
    b_abs     = b[WIDTH-1] ? (-b) : b;
    a_is_min  = (a == {1'b1, {(WIDTH-1){1'b0}}});
    b_is_neg1 = (b == {WIDTH{1'b1}});

    p_shift = {p_q, d_q[WIDTH-1]};
    q_bit   = (p_shift >= {1'b0, babs_q});
    if (q_bit) begin
      p_next = WIDTH'(p_shift - {1'b0, babs_q});
    end else begin
      p_next = p_shift[WIDTH-1:0];
    end
    d_next = {d_q[WIDTH-2:0], q_bit};

    // Negating the magnitude quotient wraps most-negative / -1 back to most-negative
    q_res = sign_q_q ? (-d_next) : d_next;
    r_res = sign_r_q ? (-p_next) : p_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      p_q      <= '0;
      d_q      <= '0;
      babs_q   <= '0;
      cnt_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      ovf_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      q        <= '0;
      r        <= '0;
      overflow <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            busy     <= 1'b1;
            overflow <= 1'b0;
            div_zero <= 1'b0;
            if (b == '0) begin
              // Nothing to iterate: report straight away
              state_q  <= StDone;
              done     <= 1'b1;
              q        <= '1;
              r        <= a;
              div_zero <= 1'b1;
            end else begin
              state_q  <= StCalc;
              p_q      <= '0;
              d_q      <= a_abs;
              babs_q   <= b_abs;
              cnt_q    <= '0;
              sign_q_q <= a[WIDTH-1] ^ b[WIDTH-1];
              sign_r_q <= a[WIDTH-1];
              ovf_q    <= a_is_min && b_is_neg1;
            end
          end
        end

        StCalc: begin
          p_q   <= p_next;
          d_q   <= d_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_q  <= StDone;
            done     <= 1'b1;
            q        <= q_res;
            r        <= r_res;
            overflow <= ovf_q;
          end
        end

        StDone: begin
          state_q <= StIdle;
          done    <= 1'b0;
          busy    <= 1'b0;
        end

        default: begin
          state_q <= StIdle;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_divider_seq.sv
module tb_signed_divider_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a, b;
  logic       busy, done, overflow, div_zero;
  logic [3:0] q, r;

  int n_total = 0;
  int n_pass  = 0;

  signed_divider_seq #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .q        (q),
    .r        (r),
    .overflow (overflow),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       ovf;
    logic       dz;
    int         lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Start in cycle N; returns k such that done was first seen in cycle N+k (20 = timeout).
  task automatic do_op(input logic [3:0] ta, input logic [3:0] tb, output int lat);
    @(negedge clk);
    a = ta;
    b = tb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic apply(input string name, input logic [3:0] ta, input logic [3:0] tb,
                       input logic [3:0] eq, input logic [3:0] er, input logic eovf,
                       input logic edz, input int elat);
    int lat;
    do_op(ta, tb, lat);
    check({name, " latency"}, lat, elat);
    check({name, " q"}, int'(q), int'(eq));
    check({name, " r"}, int'(r), int'(er));
    check({name, " overflow"}, int'(overflow), int'(eovf));
    check({name, " div_zero"}, int'(div_zero), int'(edz));
    check({name, " busy at done"}, int'(busy), 1);
    @(negedge clk);
    check({name, " done pulse width"}, int'(done), 0);
    check({name, " busy after done"}, int'(busy), 0);
    check({name, " q held"}, int'(q), int'(eq));
  endtask

  initial begin
    int lat;
    int sa, sb, eq, er;
    int last_done, low_cnt, n_done;

    vecs[0]  = '{a: 4'h7, b: 4'h2, q: 4'h3, r: 4'h1, ovf: 1'b0, dz: 1'b0, lat: 5};
    vecs[1]  = '{a: 4'h9, b: 4'h2, q: 4'hD, r: 4'hF, ovf: 1'b0, dz: 1'b0, lat: 5};
    vecs[2]  = '{a: 4'h7, b: 4'hE, q: 4'hD, r: 4'h1, ovf: 1'b0, dz: 1'b0, lat: 5};
    vecs[3]  = '{a: 4'h9, b: 4'hE, q: 4'h3, r: 4'hF, ovf: 1'b0, dz: 1'b0, lat: 5};
    vecs[4]  = '{a: 4'h8, b: 4'h3, q: 4'hE, r: 4'hE, ovf: 1'b0, dz: 1'b0, lat: 5};
    vecs[5]  = '{a: 4'h8, b: 4'hF, q: 4'h8, r: 4'h0, ovf: 1'b1, dz: 1'b0, lat: 5};
    vecs[6]  = '{a: 4'h8, b: 4'h1, q: 4'h8, r: 4'h0, ovf: 1'b0, dz: 1'b0, lat: 5};
    vecs[7]  = '{a: 4'h5, b: 4'h0, q: 4'hF, r: 4'h5, ovf: 1'b0, dz: 1'b1, lat: 1};
    vecs[8]  = '{a: 4'h0, b: 4'h3, q: 4'h0, r: 4'h0, ovf: 1'b0, dz: 1'b0, lat: 5};
    vecs[9]  = '{a: 4'h3, b: 4'h7, q: 4'h0, r: 4'h3, ovf: 1'b0, dz: 1'b0, lat: 5};
    vecs[10] = '{a: 4'h7, b: 4'h7, q: 4'h1, r: 4'h0, ovf: 1'b0, dz: 1'b0, lat: 5};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset q", int'(q), 0);
    check("reset r", int'(r), 0);
    check("reset overflow", int'(overflow), 0);
    check("reset div_zero", int'(div_zero), 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      apply($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
            vecs[i].ovf, vecs[i].dz, vecs[i].lat);
    end

    // Flags clear on the next accepted start: div_zero set by a /0, then a normal op
    apply("dz set", 4'h3, 4'h0, 4'hF, 4'h3, 1'b0, 1'b1, 1);
    apply("dz clear", 4'h6, 4'h3, 4'h2, 4'h0, 1'b0, 1'b0, 5);

    // Start pulsed mid-calculation with new operands is ignored
    @(negedge clk);
    a = 4'h7; b = 4'h2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mid busy", int'(busy), 1);
    @(negedge clk);
    a = 4'h3; b = 4'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 3;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("mid latency", lat, 5);
    check("mid q", int'(q), 3);
    check("mid r", int'(r), 1);
    @(negedge clk);
    check("mid no retrigger", int'(busy), 0);

    // Reset in the second calculation cycle aborts with no done
    @(negedge clk);
    a = 4'h7; b = 4'h2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort q", int'(q), 0);
    check("abort r", int'(r), 0);
    check("abort overflow", int'(overflow), 0);
    check("abort div_zero", int'(div_zero), 0);
    n_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("abort stays idle", n_done, 0);

    // Exhaustive sweep against an integer reference model
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        sa = $signed(4'(ia));
        sb = $signed(4'(ib));
        if (sb == 0) begin
          eq = -1; er = sa;
        end else if (sa == -8 && sb == -1) begin
          eq = -8; er = 0;
        end else begin
          eq = sa / sb; er = sa % sb;
        end
        do_op(4'(ia), 4'(ib), lat);
        check($sformatf("sweep %0d/%0d latency", sa, sb), lat, (sb == 0) ? 1 : 5);
        check($sformatf("sweep %0d/%0d q", sa, sb), int'(q), eq & 15);
        check($sformatf("sweep %0d/%0d r", sa, sb), int'(r), er & 15);
        check($sformatf("sweep %0d/%0d overflow", sa, sb), int'(overflow),
              (sa == -8 && sb == -1) ? 1 : 0);
        check($sformatf("sweep %0d/%0d div_zero", sa, sb), int'(div_zero), (sb == 0) ? 1 : 0);
      end
    end

    // Held start: done every 6 cycles, busy low exactly one cycle in each gap
    @(negedge clk);
    @(negedge clk);
    a = 4'h7; b = 4'h2; start = 1'b1;
    last_done = -1;
    low_cnt = 0;
    n_done = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (!busy) low_cnt++;
      if (done) begin
        if (last_done < 0) begin
          check("held first done", cyc, 5);
        end else begin
          check("held done spacing", cyc - last_done, 6);
          check("held busy gap", low_cnt, 1);
        end
        check("held q", int'(q), 3);
        last_done = cyc;
        low_cnt = 0;
        n_done++;
      end
    end
    check("held done count", n_done, 5);
    start = 1'b0;
    lat = 0;
    while (busy && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("held returns idle", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
